id_ex_skid_reg: RTL and testbench

Parametrised ID/EX pipeline register for the 32-bit MIPS pipeline. It replaces the free-running ID/EX latch with a valid/ready stage that adds several behaviours:
- stall through backpressure,
- flush to bubble,
- a 2-entry skid buffer, so the upstream ready is registered.

It sits between decode/register-read and execute, and feeds the forwarding unit and the RegDst mux.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/id_ex_slot.sv | 36 +++
 rtl/id_ex_skid_reg.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 32-bit MIPS pipeline.
//
// Contents:
//   PIPE_*_W         default field widths used for stored payloads
//   stage_state_t    occupancy state of a 2-entry valid/ready stage
//   id_ex_ctrl_t     the seven ID/EX control fields
//   id_ex_payload_t  control + operands + register specifiers
//   CTRL_NOP         bubble control word (no register or memory side effect)
package pipe_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_REG_ADDR_W = 5;
    localparam int PIPE_ALU_OP_W   = 2;

    // Encoding doubles as the occupancy count (0, 1, 2 entries held).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_to_reg;
        logic                     mem_read;
        logic                     mem_write;
        logic                     reg_dst;
        logic                     alu_src;
        logic [PIPE_ALU_OP_W-1:0] alu_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        id_ex_ctrl_t                ctrl;
        logic [PIPE_DATA_W-1:0]     rd1;
        logic [PIPE_DATA_W-1:0]     rd2;
        logic [PIPE_DATA_W-1:0]     sext;
        logic [PIPE_REG_ADDR_W-1:0] rs;
        logic [PIPE_REG_ADDR_W-1:0] rt;
        logic [PIPE_REG_ADDR_W-1:0] rd;
    } id_ex_payload_t;

    localparam id_ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_slot.sv
// One ID/EX payload register (used for both the MAIN and SKID slots).
//
// Ports:
//   clk           pipeline clock
//   reset         asynchronous active-high clear of the whole payload
//   load_i        capture d_i on the next rising edge
//   clear_ctrl_i  replace the control field with CTRL_NOP; operands and
//                 specifiers are kept. Takes priority over load_i.
//   d_i           payload to capture
//   q_o           stored payload
module id_ex_slot
    import pipe_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           clear_ctrl_i,
    input  id_ex_payload_t d_i,
    output id_ex_payload_t q_o
);

    id_ex_payload_t slot_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else if (clear_ctrl_i) begin
            slot_q.ctrl <= CTRL_NOP;
        end else if (load_i) begin
            slot_q <= d_i;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush-to-bubble and a
// 2-entry skid buffer so that in_ready is a register output and never
// depends combinationally on out_ready.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   flush_in                synchronous flush, empties the stage
//   in_valid / in_ready     decode-side handshake (in_ready registered)
//   *_in                    control bits, operands and specifiers from decode
//   out_valid / out_ready   execute-side handshake
//   *_out                   head (MAIN) entry; memory/regfile write controls
//                           are forced low while out_valid is low
//   Rs_out, Rt_out          head specifiers for the forwarding unit
//   Dst_out                 destination register: RegDst_out ? Rd : Rt
//   occupancy_out           entries held (0, 1, 2)
//
// Storage uses the pipe_pkg payload layout; the width parameters are
// expected to match the PIPE_*_W package widths.
module id_ex_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
    parameter int ALU_OP_W   = PIPE_ALU_OP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  RegWrite_in,
    input  logic                  MemtoReg_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  RegDst_in,
    input  logic                  ALU_Src_in,
    input  logic [ALU_OP_W-1:0]   ALU_Op_in,
    input  logic [DATA_W-1:0]     Read_Data_1_in,
    input  logic [DATA_W-1:0]     Read_Data_2_in,
    input  logic [DATA_W-1:0]     sign_extend_in,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs_in,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rt_in,
    input  logic [REG_ADDR_W-1:0] ID_Rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  RegWrite_out,
    output logic                  MemtoReg_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic                  RegDst_out,
    output logic                  ALU_Src_out,
    output logic [ALU_OP_W-1:0]   ALU_Op_out,
    output logic [DATA_W-1:0]     Read_Data_1_out,
    output logic [DATA_W-1:0]     Read_Data_2_out,
    output logic [DATA_W-1:0]     sign_extend_out,
    output logic [REG_ADDR_W-1:0] Rs_out,
    output logic [REG_ADDR_W-1:0] Rt_out,
    output logic [REG_ADDR_W-1:0] Dst_out,
    output logic [1:0]            occupancy_out
);

    stage_state_t   state_q, state_d;
    logic           in_ready_q;
    id_ex_payload_t in_payload, main_d, main_q, skid_q;
    logic           main_load, skid_load, main_from_skid;
    logic           in_xfer, out_xfer;

    always_comb begin
        in_payload.ctrl.reg_write  = RegWrite_in;
        in_payload.ctrl.mem_to_reg = MemtoReg_in;
        in_payload.ctrl.mem_read   = MemRead_in;
        in_payload.ctrl.mem_write  = MemWrite_in;
        in_payload.ctrl.reg_dst    = RegDst_in;
        in_payload.ctrl.alu_src    = ALU_Src_in;
        in_payload.ctrl.alu_op     = PIPE_ALU_OP_W'(ALU_Op_in);
        in_payload.rd1             = PIPE_DATA_W'(Read_Data_1_in);
        in_payload.rd2             = PIPE_DATA_W'(Read_Data_2_in);
        in_payload.sext            = PIPE_DATA_W'(sign_extend_in);
        in_payload.rs              = PIPE_REG_ADDR_W'(IF_ID_Rs_in);
        in_payload.rt              = PIPE_REG_ADDR_W'(IF_ID_Rt_in);
        in_payload.rd              = PIPE_REG_ADDR_W'(ID_Rd_in);
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Next state and slot load enables. A flush overrides every transfer:
    // an accepted input is dropped, and a completing output needs no action
    // because the stage is emptied anyway.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush_in) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (out_xfer) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the skid entry can move.
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            state_d = EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    // in_ready is registered from the next state so it equals
    // (state_q != FULL) without a combinational path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    id_ex_slot u_main (
        .clk          (clk),
        .reset        (reset),
        .load_i       (main_load),
        .clear_ctrl_i (flush_in),
        .d_i          (main_d),
        .q_o          (main_q)
    );

    id_ex_slot u_skid (
        .clk          (clk),
        .reset        (reset),
        .load_i       (skid_load),
        .clear_ctrl_i (flush_in),
        .d_i          (in_payload),
        .q_o          (skid_q)
    );

    // Side-effecting controls are gated so an empty stage looks like a NOP
    // to execute; everything else just shows the last MAIN contents.
    assign RegWrite_out    = main_q.ctrl.reg_write  & out_valid;
    assign MemtoReg_out    = main_q.ctrl.mem_to_reg & out_valid;
    assign MemRead_out     = main_q.ctrl.mem_read   & out_valid;
    assign MemWrite_out    = main_q.ctrl.mem_write  & out_valid;
    assign RegDst_out      = main_q.ctrl.reg_dst;
    assign ALU_Src_out     = main_q.ctrl.alu_src;
    assign ALU_Op_out      = ALU_OP_W'(main_q.ctrl.alu_op);
    assign Read_Data_1_out = DATA_W'(main_q.rd1);
    assign Read_Data_2_out = DATA_W'(main_q.rd2);
    assign sign_extend_out = DATA_W'(main_q.sext);
    assign Rs_out          = REG_ADDR_W'(main_q.rs);
    assign Rt_out          = REG_ADDR_W'(main_q.rt);
    assign Dst_out         = main_q.ctrl.reg_dst ? REG_ADDR_W'(main_q.rd)
                                                 : REG_ADDR_W'(main_q.rt);
    assign occupancy_out   = state_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Randomised + directed bench for id_ex_skid_reg against a queue model.
module tb_id_ex_skid_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush_in, in_valid, out_ready;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in;
    logic [1:0]  ALU_Op_in;
    logic [31:0] Read_Data_1_in, Read_Data_2_in, sign_extend_in;
    logic [4:0]  IF_ID_Rs_in, IF_ID_Rt_in, ID_Rd_in;
    logic        in_ready, out_valid;
    logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegDst_out, ALU_Src_out;
    logic [1:0]  ALU_Op_out;
    logic [31:0] Read_Data_1_out, Read_Data_2_out, sign_extend_out;
    logic [4:0]  Rs_out, Rt_out, Dst_out;
    logic [1:0]  occupancy_out;

    always #5 clk = ~clk;

    id_ex_skid_reg dut (
        .clk(clk), .reset(reset), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in), .ALU_Src_in(ALU_Src_in),
        .ALU_Op_in(ALU_Op_in), .Read_Data_1_in(Read_Data_1_in), .Read_Data_2_in(Read_Data_2_in),
        .sign_extend_in(sign_extend_in), .IF_ID_Rs_in(IF_ID_Rs_in), .IF_ID_Rt_in(IF_ID_Rt_in),
        .ID_Rd_in(ID_Rd_in), .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .RegDst_out(RegDst_out), .ALU_Src_out(ALU_Src_out),
        .ALU_Op_out(ALU_Op_out), .Read_Data_1_out(Read_Data_1_out),
        .Read_Data_2_out(Read_Data_2_out), .sign_extend_out(sign_extend_out),
        .Rs_out(Rs_out), .Rt_out(Rt_out), .Dst_out(Dst_out), .occupancy_out(occupancy_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of accepted entries plus the last head entry
    // (what the data outputs keep showing once the stage drains).
    id_ex_payload_t mq[$];
    id_ex_payload_t shadow;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic id_ex_payload_t rand_payload();
        id_ex_payload_t p;
        p.ctrl = id_ex_ctrl_t'($urandom_range(0, 255));
        p.rd1  = $urandom;
        p.rd2  = $urandom;
        p.sext = $urandom;
        p.rs   = 5'($urandom);
        p.rt   = 5'($urandom);
        p.rd   = 5'($urandom);
        return p;
    endfunction

    function automatic logic [127:0] exp_vec(input id_ex_payload_t p, input bit v);
        id_ex_ctrl_t c;
        c = p.ctrl;
        if (!v) begin
            c.reg_write  = 1'b0;
            c.mem_to_reg = 1'b0;
            c.mem_read   = 1'b0;
            c.mem_write  = 1'b0;
        end
        return 128'({c, p.rd1, p.rd2, p.sext, p.rs, p.rt, (c.reg_dst ? p.rd : p.rt)});
    endfunction

    function automatic logic [127:0] obs_vec();
        return 128'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegDst_out,
                     ALU_Src_out, ALU_Op_out, Read_Data_1_out, Read_Data_2_out,
                     sign_extend_out, Rs_out, Rt_out, Dst_out});
    endfunction

    task automatic drive(input id_ex_payload_t p);
        RegWrite_in    = p.ctrl.reg_write;
        MemtoReg_in    = p.ctrl.mem_to_reg;
        MemRead_in     = p.ctrl.mem_read;
        MemWrite_in    = p.ctrl.mem_write;
        RegDst_in      = p.ctrl.reg_dst;
        ALU_Src_in     = p.ctrl.alu_src;
        ALU_Op_in      = p.ctrl.alu_op;
        Read_Data_1_in = p.rd1;
        Read_Data_2_in = p.rd2;
        sign_extend_in = p.sext;
        IF_ID_Rs_in    = p.rs;
        IF_ID_Rt_in    = p.rt;
        ID_Rd_in       = p.rd;
    endtask

    task automatic model_reset();
        mq.delete();
        shadow = '0;
    endtask

    task automatic compare_outputs(input string where);
        bit v;
        v = (mq.size() != 0);
        check({where, "_in_ready"},  128'(in_ready),      128'(mq.size() != 2));
        check({where, "_out_valid"}, 128'(out_valid),     128'(v));
        check({where, "_occupancy"}, 128'(occupancy_out), 128'(mq.size()));
        check({where, "_head"},      obs_vec(),           exp_vec(shadow, v));
    endtask

    // One clock: drive at negedge, check the current state, then advance the
    // model with the handshake that the edge will see.
    task automatic step(input string where, input logic v, input id_ex_payload_t p,
                        input logic ordy, input logic fl, output logic acc);
        bit out_x;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        flush_in  = fl;
        drive(p);
        compare_outputs(where);
        acc   = v && (mq.size() < 2);
        out_x = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            if (mq.size() != 0) shadow = mq[0];
            shadow.ctrl = CTRL_NOP;
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (acc)   mq.push_back(p);
            if (mq.size() != 0) shadow = mq[0];
        end
        $display("[TB] %s v=%0b rdy=%0b fl=%0b acc=%0b occ_model=%0d", where, v, ordy, fl, acc, mq.size());
    endtask

    task automatic async_reset_check(input string where);
        #2 reset = 1'b1;
        #1;
        check({where, "_in_ready"},  128'(in_ready),      128'(1));
        check({where, "_out_valid"}, 128'(out_valid),     128'(0));
        check({where, "_occupancy"}, 128'(occupancy_out), 128'(0));
        check({where, "_outputs"},   obs_vec(),           128'(0));
        model_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        id_ex_payload_t p, pend;
        id_ex_payload_t pb[3];
        logic acc;
        int   guard;

        reset = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        step("rst_state", 1'b0, '0, 1'b0, 1'b0, acc);

        // Reset mid-cycle, then a first entry RD1=A, RegWrite=1.
        @(negedge clk);
        async_reset_check("rst_mid");
        p = '0; p.ctrl.reg_write = 1'b1; p.rd1 = 32'hA;
        step("first_push", 1'b1, p, 1'b1, 1'b0, acc);
        step("first_seen", 1'b0, '0, 1'b1, 1'b0, acc);

        // Backpressure: 1, 2 captured, 3 held upstream until ready returns.
        for (int k = 0; k < 3; k++) begin
            pb[k] = rand_payload();
            pb[k].rd1 = 32'(k + 1);
        end
        step("bp_push1", 1'b1, pb[0], 1'b0, 1'b0, acc);
        step("bp_push2", 1'b1, pb[1], 1'b0, 1'b0, acc);
        step("bp_push3", 1'b1, pb[2], 1'b0, 1'b0, acc);
        step("bp_hold3", 1'b1, pb[2], 1'b0, 1'b0, acc);
        guard = 0;
        do begin
            step("bp_drain", 1'b1, pb[2], 1'b1, 1'b0, acc);
            guard++;
        end while (!acc && guard < 6);
        check("bp_accept3_in_budget", 128'(guard < 6), 128'(1));
        repeat (4) step("bp_tail", 1'b0, '0, 1'b1, 1'b0, acc);

        // Full throughput.
        for (int i = 0; i < 8; i++) begin
            step("thru", 1'b1, rand_payload(), 1'b1, 1'b0, acc);
            #1 check("thru_occ_le1", 128'(occupancy_out <= 2'd1), 128'(1));
        end
        repeat (2) step("thru_tail", 1'b0, '0, 1'b1, 1'b0, acc);

        // Flush while FULL with a store presented in the same cycle.
        step("fl_push1", 1'b1, rand_payload(), 1'b0, 1'b0, acc);
        step("fl_push2", 1'b1, rand_payload(), 1'b0, 1'b0, acc);
        p = rand_payload(); p.ctrl.mem_write = 1'b1;
        step("fl_flush", 1'b1, p, 1'b0, 1'b1, acc);
        repeat (3) step("fl_after", 1'b0, '0, 1'b1, 1'b0, acc);

        // Destination mux.
        p = rand_payload(); p.ctrl.reg_dst = 1'b1; p.rd = 5'd9; p.rt = 5'd4;
        step("dst_rd_push", 1'b1, p, 1'b1, 1'b0, acc);
        #1 check("dst_rd", 128'(Dst_out), 128'(9));
        p.ctrl.reg_dst = 1'b0;
        step("dst_rt_push", 1'b1, p, 1'b1, 1'b0, acc);
        #1 check("dst_rt", 128'(Dst_out), 128'(4));
        step("dst_tail", 1'b0, '0, 1'b1, 1'b0, acc);

        // Asynchronous reset while holding two entries.
        step("ar_push1", 1'b1, rand_payload(), 1'b0, 1'b0, acc);
        step("ar_push2", 1'b1, rand_payload(), 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b1;
        drive(rand_payload());
        async_reset_check("ar_full");
        repeat (3) step("ar_after", 1'b0, '0, 1'b1, 1'b0, acc);

        // Random traffic with a well-behaved producer (holds until accepted).
        pend = rand_payload();
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), pend, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 24) == 0), acc);
            if (acc) pend = rand_payload();
        end
        step("final", 1'b0, '0, 1'b0, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
